// File: rtl/axi_burst_pkg.sv
// Shared widths and FSM state type for the AXI-style burst master.
package axi_burst_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned WAIT_W = 11;

  typedef enum logic [2:0] {
    StIdle,
    StWaddr,
    StWdata,
    StRaddr,
    StRdata
  } state_e;

endpackage

// File: rtl/axi_burst_master.sv
// Single-outstanding burst master: one address phase, then LEN+1 data beats passed
// straight between the user streams and the slave, with sticky protocol error flags.
module axi_burst_master
  import axi_burst_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [STRB_W-1:0] wstrb_in,
  input  logic              wdata_in_valid,
  output logic              wdata_in_ready,
  output logic [DATA_W-1:0] rdata_out,
  output logic [ID_W-1:0]   rdata_out_id,
  output logic              rdata_out_last,
  output logic              rdata_out_valid,
  input  logic              rdata_out_ready,
  output logic              done,
  output logic [ID_W-1:0]   done_id,
  output logic              err_id,
  output logic              err_last,
  output logic              err_timeout,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [LEN_W-1:0]  WR_LEN,
  output logic [ID_W-1:0]   WR_ID,
  output logic              WR_ADDR_VALID,
  input  logic              WR_ADDR_READY,
  output logic [DATA_W-1:0] WR_DATA,
  output logic [STRB_W-1:0] WR_STRB,
  output logic              WR_DATA_VALID,
  output logic              WR_DATA_LAST,
  input  logic              WR_DATA_READY,
  input  logic [ID_W-1:0]   WR_BACK_ID,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic [LEN_W-1:0]  RD_LEN,
  output logic [ID_W-1:0]   RD_ID,
  output logic              RD_ADDR_VALID,
  input  logic              RD_ADDR_READY,
  input  logic [DATA_W-1:0] RD_DATA,
  input  logic [ID_W-1:0]   RD_BACK_ID,
  input  logic              RD_DATA_LAST,
  input  logic              RD_DATA_VALID,
  output logic              RD_DATA_READY
);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q, beat_cnt_q;
  logic [ID_W-1:0]     id_q, done_id_q;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_inc;
  logic ready_q, addr_valid_q, done_q, err_id_q, err_last_q, err_timeout_q;
  logic in_waddr, in_raddr, in_wdata, in_rdata, last_beat;
  logic a_hs, w_hs, r_hs, progress, set_id, set_last, set_timeout;

  assign in_waddr  = (state_q == StWaddr);
  assign in_raddr  = (state_q == StRaddr);
  assign in_wdata  = (state_q == StWdata);
  assign in_rdata  = (state_q == StRdata);
  assign last_beat = (beat_cnt_q == len_q);

  assign a_hs     = addr_valid_q && ((in_waddr && WR_ADDR_READY) || (in_raddr && RD_ADDR_READY));
  assign w_hs     = in_wdata && wdata_in_valid && WR_DATA_READY;
  assign r_hs     = in_rdata && RD_DATA_VALID && rdata_out_ready;
  assign progress = a_hs || w_hs || r_hs;

  // Saturating stall count; compared against TIMEOUT as the value it is about to take.
  assign wait_inc    = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
  assign set_timeout = (TIMEOUT != 0) && (state_q != StIdle) && !progress &&
                       (32'(wait_inc) >= TIMEOUT);
  assign set_id      = (w_hs && last_beat && (WR_BACK_ID != id_q)) ||
                       (r_hs && (RD_BACK_ID != id_q));
  assign set_last    = r_hs && (RD_DATA_LAST != last_beat);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      len_q         <= '0;
      id_q          <= '0;
      beat_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      ready_q       <= 1'b0;
      addr_valid_q  <= 1'b0;
      done_q        <= 1'b0;
      done_id_q     <= '0;
      err_id_q      <= 1'b0;
      err_last_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == StIdle || progress) wait_cnt_q <= '0;
      else                               wait_cnt_q <= wait_inc;

      case (state_q)
        StIdle: begin
          if (cmd_valid && ready_q) begin
            addr_q       <= cmd_addr;
            len_q        <= cmd_len;
            id_q         <= cmd_id;
            beat_cnt_q   <= '0;
            addr_valid_q <= 1'b1;
            ready_q      <= 1'b0;
            state_q      <= cmd_wr ? StWaddr : StRaddr;
          end else begin
            ready_q <= 1'b1;
          end
        end
        StWaddr, StRaddr: begin
          if (a_hs) begin
            addr_valid_q <= 1'b0;
            state_q      <= in_waddr ? StWdata : StRdata;
          end
        end
        StWdata, StRdata: begin
          // Burst length is set by the command, not by the slave's LAST.
          if (w_hs || r_hs) begin
            if (last_beat) begin
              done_q     <= 1'b1;
              done_id_q  <= id_q;
              beat_cnt_q <= '0;
              ready_q    <= 1'b1;
              state_q    <= StIdle;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      err_id_q      <= set_id      || (err_id_q      && !err_clr);
      err_last_q    <= set_last    || (err_last_q    && !err_clr);
      err_timeout_q <= set_timeout || (err_timeout_q && !err_clr);
    end
  end

  assign cmd_ready     = ready_q;
  assign WR_ADDR_VALID = in_waddr && addr_valid_q;
  assign WR_ADDR       = in_waddr ? addr_q : '0;
  assign WR_LEN        = in_waddr ? len_q  : '0;
  assign WR_ID         = in_waddr ? id_q   : '0;
  assign RD_ADDR_VALID = in_raddr && addr_valid_q;
  assign RD_ADDR       = in_raddr ? addr_q : '0;
  assign RD_LEN        = in_raddr ? len_q  : '0;
  assign RD_ID         = in_raddr ? id_q   : '0;

  assign WR_DATA_VALID  = in_wdata && wdata_in_valid;
  assign wdata_in_ready = in_wdata && WR_DATA_READY;
  assign WR_DATA        = in_wdata ? wdata_in : '0;
  assign WR_STRB        = in_wdata ? wstrb_in : '0;
  assign WR_DATA_LAST   = in_wdata && last_beat;

  assign RD_DATA_READY   = in_rdata && rdata_out_ready;
  assign rdata_out_valid = in_rdata && RD_DATA_VALID;
  assign rdata_out       = in_rdata ? RD_DATA    : '0;
  assign rdata_out_id    = in_rdata ? RD_BACK_ID : '0;
  assign rdata_out_last  = in_rdata && RD_DATA_LAST;

  assign done        = done_q;
  assign done_id     = done_id_q;
  assign err_id      = err_id_q;
  assign err_last    = err_last_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// Randomized bench for axi_burst_master: the bench plays user and slave, keeps a word
// memory model, and checks every beat, done pulse and error flag against it.
module tb_axi_burst_master;
  import axi_burst_pkg::*;

  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_wr;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [3:0]  cmd_id;
  logic [31:0] wdata_in;
  logic [3:0]  wstrb_in;
  logic wdata_in_valid, wdata_in_ready;
  logic [31:0] rdata_out;
  logic [3:0]  rdata_out_id;
  logic rdata_out_last, rdata_out_valid, rdata_out_ready;
  logic done;
  logic [3:0] done_id;
  logic err_id, err_last, err_timeout, err_clr;
  logic [31:0] WR_ADDR, RD_ADDR, WR_DATA, RD_DATA;
  logic [7:0]  WR_LEN, RD_LEN;
  logic [3:0]  WR_ID, RD_ID, WR_STRB, WR_BACK_ID, RD_BACK_ID;
  logic WR_ADDR_VALID, WR_ADDR_READY, WR_DATA_VALID, WR_DATA_LAST, WR_DATA_READY;
  logic RD_ADDR_VALID, RD_ADDR_READY, RD_DATA_LAST, RD_DATA_VALID, RD_DATA_READY;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] mem [logic [31:0]];
  logic any_out;

  always #5 clk = ~clk;

  axi_burst_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wdata_in(wdata_in), .wstrb_in(wstrb_in), .wdata_in_valid(wdata_in_valid),
    .wdata_in_ready(wdata_in_ready),
    .rdata_out(rdata_out), .rdata_out_id(rdata_out_id), .rdata_out_last(rdata_out_last),
    .rdata_out_valid(rdata_out_valid), .rdata_out_ready(rdata_out_ready),
    .done(done), .done_id(done_id),
    .err_id(err_id), .err_last(err_last), .err_timeout(err_timeout), .err_clr(err_clr),
    .WR_ADDR(WR_ADDR), .WR_LEN(WR_LEN), .WR_ID(WR_ID), .WR_ADDR_VALID(WR_ADDR_VALID),
    .WR_ADDR_READY(WR_ADDR_READY),
    .WR_DATA(WR_DATA), .WR_STRB(WR_STRB), .WR_DATA_VALID(WR_DATA_VALID),
    .WR_DATA_LAST(WR_DATA_LAST), .WR_DATA_READY(WR_DATA_READY), .WR_BACK_ID(WR_BACK_ID),
    .RD_ADDR(RD_ADDR), .RD_LEN(RD_LEN), .RD_ID(RD_ID), .RD_ADDR_VALID(RD_ADDR_VALID),
    .RD_ADDR_READY(RD_ADDR_READY),
    .RD_DATA(RD_DATA), .RD_BACK_ID(RD_BACK_ID), .RD_DATA_LAST(RD_DATA_LAST),
    .RD_DATA_VALID(RD_DATA_VALID), .RD_DATA_READY(RD_DATA_READY)
  );

  assign any_out = |{cmd_ready, wdata_in_ready, rdata_out, rdata_out_id, rdata_out_last,
                     rdata_out_valid, done, done_id, err_id, err_last, err_timeout,
                     WR_ADDR, WR_LEN, WR_ID, WR_ADDR_VALID, WR_DATA, WR_STRB, WR_DATA_VALID,
                     WR_DATA_LAST, RD_ADDR, RD_LEN, RD_ID, RD_ADDR_VALID, RD_DATA_READY};

  task automatic clear_inputs();
    cmd_valid = 0; cmd_wr = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    wdata_in = '0; wstrb_in = '0; wdata_in_valid = 0; rdata_out_ready = 0; err_clr = 0;
    WR_ADDR_READY = 0; WR_DATA_READY = 0; WR_BACK_ID = '0;
    RD_ADDR_READY = 0; RD_DATA = '0; RD_BACK_ID = '0; RD_DATA_LAST = 0; RD_DATA_VALID = 0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
  endtask

  task automatic issue_cmd(input bit wr, input logic [31:0] a, input logic [7:0] l,
                           input logic [3:0] id);
    int t = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_wr = wr; cmd_addr = a; cmd_len = l; cmd_id = id;
    #1;
    while (cmd_ready !== 1'b1 && t < 50) begin @(negedge clk); #1; t++; end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 0;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL cmd_ready_busy: got %b want 0", cmd_ready);
    end
  endtask

  task automatic addr_phase(input bit wr, input logic [31:0] a, input logic [7:0] l,
                            input logic [3:0] id, input int dly);
    logic [44:0] got;
    for (int i = 0; i <= dly; i++) begin
      got = wr ? {WR_ADDR_VALID, WR_ADDR, WR_LEN, WR_ID} : {RD_ADDR_VALID, RD_ADDR, RD_LEN, RD_ID};
      n_cmp++;
      if (got !== {1'b1, a, l, id}) begin
        n_fail++; $display("FAIL addr_hold: got %h want %h", got, {1'b1, a, l, id});
      end
      if (i == dly) begin
        if (wr) WR_ADDR_READY = 1; else RD_ADDR_READY = 1;
      end
      @(negedge clk);
    end
    WR_ADDR_READY = 0; RD_ADDR_READY = 0;
    n_cmp++;
    if ((wr ? WR_ADDR_VALID : RD_ADDR_VALID) !== 1'b0) begin
      n_fail++; $display("FAIL addr_drop: got 1 want 0");
    end
  endtask

  task automatic run_write(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id,
                           input int adly, input bit directed, input int abort_beat);
    logic [31:0] wd[$];
    logic [3:0]  ws[$];
    logic [31:0] d, w;
    logic [3:0]  s;
    int beat = 0, cyc = 0, stall = 0;
    for (int i = 0; i <= int'(l); i++) begin
      wd.push_back(directed ? 32'hA0 + i : $urandom);
      ws.push_back(directed ? 4'hF : 4'($urandom));
    end
    issue_cmd(1'b1, a, l, id);
    addr_phase(1'b1, a, l, id, adly);
    WR_BACK_ID = id;
    while (beat <= int'(l) && cyc < 4000) begin
      d = wd[beat]; s = ws[beat];
      wdata_in = d; wstrb_in = s;
      wdata_in_valid = directed || ($urandom_range(0, 3) != 0) || stall >= 6;
      WR_DATA_READY  = directed || ($urandom_range(0, 3) != 0) || stall >= 6;
      #1;
      if (beat == abort_beat && wdata_in_valid) begin
        #2 rst = 0;
        #1;
        n_cmp++;
        if (any_out !== 1'b0) begin
          n_fail++; $display("FAIL reset_mid_burst: outputs nonzero got %b want 0", any_out);
        end
        clear_inputs();
        @(negedge clk); rst = 1;
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, done} !== 2'b10) begin
          n_fail++; $display("FAIL reset_recover: got %b want 10", {cmd_ready, done});
        end
        return;
      end
      n_cmp++;
      if ({WR_DATA_VALID, wdata_in_ready, done} !== {wdata_in_valid, WR_DATA_READY, 1'b0}) begin
        n_fail++; $display("FAIL wr_pass: got %b want %b", {WR_DATA_VALID, wdata_in_ready, done},
                           {wdata_in_valid, WR_DATA_READY, 1'b0});
      end
      if (wdata_in_valid) begin
        n_cmp++;
        if ({WR_DATA, WR_STRB, WR_DATA_LAST} !== {d, s, beat == int'(l)}) begin
          n_fail++; $display("FAIL wr_beat%0d: got %h want %h", beat,
                             {WR_DATA, WR_STRB, WR_DATA_LAST}, {d, s, beat == int'(l)});
        end
      end
      if (wdata_in_valid && WR_DATA_READY) begin
        w = mem.exists(a + beat) ? mem[a + beat] : 32'h0;
        for (int k = 0; k < 4; k++) if (s[k]) w[8*k +: 8] = d[8*k +: 8];
        mem[a + beat] = w;
        beat++; stall = 0;
      end else begin
        stall++;
      end
      @(negedge clk); cyc++;
    end
    wdata_in_valid = 0; WR_DATA_READY = 0;
    n_cmp++;
    if ({done, done_id, cmd_ready} !== {1'b1, id, 1'b1}) begin
      n_fail++; $display("FAIL wr_done: got %h want %h", {done, done_id, cmd_ready}, {1'b1, id, 1'b1});
    end
    @(negedge clk);
    n_cmp++;
    if ({done, err_id, err_last, err_timeout} !== 4'b0) begin
      n_fail++; $display("FAIL wr_after: got %b want 0000", {done, err_id, err_last, err_timeout});
    end
  endtask

  task automatic run_read(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id,
                          input logic [3:0] back_id, input int last_at, input bit toggle,
                          input int adly);
    logic [31:0] exp_d;
    bit exp_eid = 0, exp_elast = 0, hold = 0, tog = 1;
    int beat = 0, cyc = 0, stall = 0;
    issue_cmd(1'b0, a, l, id);
    addr_phase(1'b0, a, l, id, adly);
    RD_BACK_ID = back_id;
    while (beat <= int'(l) && cyc < 4000) begin
      exp_d = mem.exists(a + beat) ? mem[a + beat] : 32'h0;
      RD_DATA = exp_d;
      RD_DATA_LAST = (last_at < 0) ? (beat == int'(l)) : (beat == last_at);
      RD_DATA_VALID = hold || ($urandom_range(0, 3) != 0) || stall >= 6;
      rdata_out_ready = toggle ? tog : (($urandom_range(0, 3) != 0) || stall >= 6);
      tog = !tog;
      #1;
      n_cmp++;
      if ({rdata_out_valid, RD_DATA_READY, done} !== {RD_DATA_VALID, rdata_out_ready, 1'b0}) begin
        n_fail++; $display("FAIL rd_pass: got %b want %b", {rdata_out_valid, RD_DATA_READY, done},
                           {RD_DATA_VALID, rdata_out_ready, 1'b0});
      end
      if (RD_DATA_VALID) begin
        n_cmp++;
        if ({rdata_out, rdata_out_id, rdata_out_last} !== {exp_d, back_id, RD_DATA_LAST}) begin
          n_fail++; $display("FAIL rd_beat%0d: got %h want %h", beat,
                             {rdata_out, rdata_out_id, rdata_out_last}, {exp_d, back_id, RD_DATA_LAST});
        end
      end
      if (RD_DATA_VALID && rdata_out_ready) begin
        exp_eid   = exp_eid || (back_id != id);
        exp_elast = exp_elast || (RD_DATA_LAST != (beat == int'(l)));
        beat++; stall = 0; hold = 0;
      end else begin
        hold = RD_DATA_VALID; stall++;
      end
      @(negedge clk); cyc++;
    end
    RD_DATA_VALID = 0; rdata_out_ready = 0; RD_DATA_LAST = 0;
    n_cmp++;
    if ({done, done_id, err_id, err_last} !== {1'b1, id, exp_eid, exp_elast}) begin
      n_fail++; $display("FAIL rd_done: got %h want %h", {done, done_id, err_id, err_last},
                         {1'b1, id, exp_eid, exp_elast});
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL rd_done_pulse: got 1 want 0"); end
  endtask

  task automatic test_reset();
    rst = 0; clear_inputs();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (any_out !== 1'b0) begin n_fail++; $display("FAIL reset_outputs: got 1 want 0"); end
    rst = 1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write_read();
    run_write(32'h10, 8'd3, 4'd5, 3, 1'b1, -1);
    run_read(32'h10, 8'd3, 4'd5, 4'd5, -1, 1'b0, 2);
  endtask

  task automatic test_read_single();
    run_read(32'h11, 8'd0, 4'd9, 4'd9, -1, 1'b1, 0);
  endtask

  task automatic test_read_errors();
    run_read(32'h10, 8'd3, 4'd5, 4'd6, 1, 1'b1, 1);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({err_id, err_last} !== 2'b11) begin
      n_fail++; $display("FAIL err_sticky: got %b want 11", {err_id, err_last});
    end
    pulse_clr();
    n_cmp++;
    if ({err_id, err_last} !== 2'b00) begin
      n_fail++; $display("FAIL err_clear: got %b want 00", {err_id, err_last});
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [7:0]  l;
    logic [3:0]  id;
    for (int n = 0; n < 6; n++) begin
      a = $urandom_range(0, 1000); l = 8'($urandom_range(0, 20)); id = 4'($urandom);
      run_write(a, l, id, $urandom_range(0, 3), 1'b0, -1);
      run_read(a, l, id, id, -1, 1'b0, $urandom_range(0, 3));
    end
    run_write(32'h1000, 8'd255, 4'd7, 1, 1'b0, -1);
    run_read(32'h1000, 8'd255, 4'd7, 4'd7, -1, 1'b0, 0);
  endtask

  task automatic test_reset_mid_burst();
    run_write(32'h200, 8'd7, 4'hA, 0, 1'b0, 2);
    run_write(32'h300, 8'd2, 4'hB, 1, 1'b0, -1);
    run_read(32'h300, 8'd2, 4'hB, 4'hB, -1, 1'b0, 0);
  endtask

  task automatic test_timeout();
    issue_cmd(1'b1, 32'h40, 8'd0, 4'd3);
    repeat (TO - 1) @(negedge clk);
    n_cmp++;
    if ({err_timeout, WR_ADDR_VALID} !== 2'b01) begin
      n_fail++; $display("FAIL timeout_early: got %b want 01", {err_timeout, WR_ADDR_VALID});
    end
    @(negedge clk);
    n_cmp++;
    if ({err_timeout, WR_ADDR_VALID} !== 2'b11) begin
      n_fail++; $display("FAIL timeout_set: got %b want 11", {err_timeout, WR_ADDR_VALID});
    end
    pulse_clr();
    n_cmp++;
    if ({err_timeout, WR_ADDR_VALID} !== 2'b11) begin
      n_fail++; $display("FAIL timeout_set_wins: got %b want 11", {err_timeout, WR_ADDR_VALID});
    end
    WR_ADDR_READY = 1;
    @(negedge clk);
    WR_ADDR_READY = 0; WR_BACK_ID = 4'd3;
    wdata_in = 32'h5A5A_0040; wstrb_in = 4'hF; wdata_in_valid = 1; WR_DATA_READY = 1;
    #1;
    n_cmp++;
    if (WR_DATA_LAST !== 1'b1) begin n_fail++; $display("FAIL len0_last: got 0 want 1"); end
    @(negedge clk);
    wdata_in_valid = 0; WR_DATA_READY = 0;
    mem[32'h40] = 32'h5A5A_0040;
    n_cmp++;
    if ({done, done_id, err_timeout} !== {1'b1, 4'd3, 1'b1}) begin
      n_fail++; $display("FAIL timeout_done: got %h want %h", {done, done_id, err_timeout},
                         {1'b1, 4'd3, 1'b1});
    end
    pulse_clr();
    n_cmp++;
    if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got 1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_single();
    test_read_errors();
    test_random();
    test_reset_mid_burst();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish got timeout want finish");
    $fatal(1);
  end

endmodule
